// File: rtl/datapath_pkg.sv
// Shared encodings for the parametrised CPU datapath.
package datapath_pkg;

  // ALU operation codes (3'b11x passes Bin through)
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_NOT = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;

  // Shifter codes applied to B
  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  // One-hot writeback select bit positions
  localparam int unsigned VSEL_C     = 0;
  localparam int unsigned VSEL_PC    = 1;
  localparam int unsigned VSEL_IMM8  = 2;
  localparam int unsigned VSEL_MDATA = 3;

  // Status register bit positions {V,N,Z}
  localparam int unsigned ST_Z = 0;
  localparam int unsigned ST_N = 1;
  localparam int unsigned ST_V = 2;
  localparam int unsigned ST_W = 3;

endpackage

// File: rtl/datapath_param_seq_mul.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per cycle.
module seq_mul #(
  parameter int unsigned DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [DATA_W-1:0]     i_a,
  input  logic [DATA_W-1:0]     i_b,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_last_c,
  output logic [2*DATA_W-1:0]   o_prod_c
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned CNT_W  = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  logic                r_busy;
  logic                r_done;
  logic [CNT_W-1:0]    r_cnt;
  logic [PROD_W-1:0]   r_acc;
  logic [PROD_W-1:0]   r_mcand;
  logic [DATA_W-1:0]   r_mplier;
  logic [PROD_W-1:0]   w_acc_nxt;

  // Partial-product accumulate for the current multiplier bit
  always_comb begin
    w_acc_nxt = r_acc;
    if (r_mplier[0]) w_acc_nxt = r_acc + r_mcand;
  end

  // Start latch, step counter and completion pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        if (i_start) begin
          r_busy   <= 1'b1;
          r_cnt    <= '0;
          r_acc    <= '0;
          r_mcand  <= PROD_W'(i_a);
          r_mplier <= i_b;
        end
      end else begin
        r_acc    <= w_acc_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
        if (r_cnt == LAST_STEP) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_last_c = r_busy && (r_cnt == LAST_STEP);
  assign o_prod_c = w_acc_nxt;

endmodule

// File: rtl/datapath_param.sv
// CPU datapath: register file, A/B/C regs, shifter, ALU, {V,N,Z} status, multiplier.
module datapath_param
  import datapath_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 8,
  parameter int unsigned PC_W   = 9
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       write,
  input  logic [$clog2(NREG)-1:0]    writenum,
  input  logic [$clog2(NREG)-1:0]    readnum,
  input  logic [3:0]                 vsel,
  input  logic [DATA_W-1:0]          mdata,
  input  logic [DATA_W-1:0]          sximm8,
  input  logic [DATA_W-1:0]          sximm5,
  input  logic [PC_W-1:0]            pc,
  input  logic                       loada,
  input  logic                       loadb,
  input  logic                       asel,
  input  logic                       bsel,
  input  logic [1:0]                 shift,
  input  logic [2:0]                 aluop,
  input  logic                       loadc,
  input  logic                       loads,
  input  logic                       mul_start,
  output logic                       mul_busy,
  output logic                       mul_done,
  output logic [ST_W-1:0]            status_out,
  output logic [DATA_W-1:0]          c_out
);

  localparam int unsigned MSB = DATA_W - 1;

  logic [DATA_W-1:0]   r_regs [NREG];
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_c;
  logic [ST_W-1:0]     r_status;

  logic [DATA_W-1:0]   w_wb_data;
  logic [DATA_W-1:0]   w_rd_data;
  logic [DATA_W-1:0]   w_b_sh;
  logic [DATA_W-1:0]   w_ain;
  logic [DATA_W-1:0]   w_bin;
  logic [DATA_W-1:0]   w_alu;
  logic                w_v;
  logic [ST_W-1:0]     w_flags;
  logic [ST_W-1:0]     w_mul_flags;
  logic                w_mul_last;
  logic [2*DATA_W-1:0] w_mul_prod;

  // Writeback data: OR of every selected source
  always_comb begin
    w_wb_data = '0;
    if (vsel[VSEL_MDATA]) w_wb_data = w_wb_data | mdata;
    if (vsel[VSEL_IMM8])  w_wb_data = w_wb_data | sximm8;
    if (vsel[VSEL_PC])    w_wb_data = w_wb_data | DATA_W'(pc);
    if (vsel[VSEL_C])     w_wb_data = w_wb_data | r_c;
  end

  // Combinational read with same-cycle write bypass
  assign w_rd_data = (write && (writenum == readnum)) ? w_wb_data : r_regs[readnum];

  // Register file
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) r_regs[i] <= '0;
    end else if (write) begin
      r_regs[writenum] <= w_wb_data;
    end
  end

  // A/B operand pipeline registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      if (loada) r_a <= w_rd_data;
      if (loadb) r_b <= w_rd_data;
    end
  end

  // Single-bit shifter on B
  always_comb begin
    w_b_sh = r_b;
    case (shift)
      SH_LSL:  w_b_sh = {r_b[MSB-1:0], 1'b0};
      SH_LSR:  w_b_sh = {1'b0, r_b[MSB:1]};
      SH_ASR:  w_b_sh = {r_b[MSB], r_b[MSB:1]};
      default: w_b_sh = r_b;
    endcase
  end

  assign w_ain = asel ? '0 : r_a;
  assign w_bin = bsel ? sximm5 : w_b_sh;

  // ALU and signed-overflow detection
  always_comb begin
    w_alu = w_bin;
    w_v   = 1'b0;
    case (aluop)
      ALU_ADD: begin
        w_alu = w_ain + w_bin;
        w_v   = (w_ain[MSB] == w_bin[MSB]) && (w_alu[MSB] != w_ain[MSB]);
      end
      ALU_SUB: begin
        w_alu = w_ain - w_bin;
        w_v   = (w_ain[MSB] != w_bin[MSB]) && (w_alu[MSB] != w_ain[MSB]);
      end
      ALU_AND: w_alu = w_ain & w_bin;
      ALU_NOT: w_alu = ~w_bin;
      ALU_OR:  w_alu = w_ain | w_bin;
      ALU_XOR: w_alu = w_ain ^ w_bin;
      default: w_alu = w_bin;
    endcase
  end

  // Status flags for ALU result and for multiplier result
  always_comb begin
    w_flags           = '0;
    w_flags[ST_V]     = w_v;
    w_flags[ST_N]     = w_alu[MSB];
    w_flags[ST_Z]     = (w_alu == '0);
    w_mul_flags       = '0;
    w_mul_flags[ST_V] = (w_mul_prod[2*DATA_W-1:DATA_W] != '0);
    w_mul_flags[ST_N] = w_mul_prod[MSB];
    w_mul_flags[ST_Z] = (w_mul_prod[MSB:0] == '0);
  end

  seq_mul #(.DATA_W(DATA_W)) u_mul (
    .clk      (clk),
    .reset    (reset),
    .i_start  (mul_start),
    .i_a      (w_ain),
    .i_b      (w_bin),
    .o_busy   (mul_busy),
    .o_done   (mul_done),
    .o_last_c (w_mul_last),
    .o_prod_c (w_mul_prod)
  );

  // C and status: multiplier owns them while busy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_c      <= '0;
      r_status <= '0;
    end else if (w_mul_last) begin
      r_c      <= w_mul_prod[MSB:0];
      r_status <= w_mul_flags;
    end else if (!mul_busy) begin
      if (loadc) r_c      <= w_alu;
      if (loads) r_status <= w_flags;
    end
  end

  assign c_out      = r_c;
  assign status_out = r_status;

endmodule

// File: tb/tb_datapath_param.sv
// Scoreboard bench for datapath_param (DATA_W=16, NREG=8, PC_W=9).
module tb_datapath_param;
  import datapath_pkg::*;

  typedef struct packed {
    logic [15:0] c;
    logic [2:0]  s;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        write;
  logic [2:0]  writenum;
  logic [2:0]  readnum;
  logic [3:0]  vsel;
  logic [15:0] mdata;
  logic [15:0] sximm8;
  logic [15:0] sximm5;
  logic [8:0]  pc;
  logic        loada;
  logic        loadb;
  logic        asel;
  logic        bsel;
  logic [1:0]  shift;
  logic [2:0]  aluop;
  logic        loadc;
  logic        loads;
  logic        mul_start;
  logic        mul_busy;
  logic        mul_done;
  logic [2:0]  status_out;
  logic [15:0] c_out;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc;
  logic loadc_d;

  datapath_param #(.DATA_W(16), .NREG(8), .PC_W(9)) dut (
    .clk(clk), .reset(reset), .write(write), .writenum(writenum), .readnum(readnum),
    .vsel(vsel), .mdata(mdata), .sximm8(sximm8), .sximm5(sximm5), .pc(pc),
    .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel), .shift(shift),
    .aluop(aluop), .loadc(loadc), .loads(loads), .mul_start(mul_start),
    .mul_busy(mul_busy), .mul_done(mul_done), .status_out(status_out), .c_out(c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  // C presents a new value one cycle after an accepted loadc
  always @(posedge clk or posedge reset) begin
    if (reset) loadc_d <= 1'b0;
    else       loadc_d <= loadc && !mul_busy;
  end

  // Monitor: pop and compare whenever C/status present a result
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (loadc_d || mul_done)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: c_out=0x%04h status=%03b with no expected entry", c_out, status_out);
      end else begin
        e = exp_q.pop_front();
        chk("c_out", c_out, e.c);
        chk("status", 16'(status_out), 16'(e.s));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wrv(input logic [2:0] n, input logic [3:0] vs);
    write = 1'b1; writenum = n; vsel = vs;
    tick();
    write = 1'b0; vsel = 4'b0000;
  endtask

  task automatic wr(input logic [2:0] n, input logic [15:0] v);
    sximm8 = v;
    wrv(n, 4'b0100);
  endtask

  task automatic ld_a(input logic [2:0] n);
    readnum = n; loada = 1'b1;
    tick();
    loada = 1'b0;
  endtask

  task automatic ld_b(input logic [2:0] n);
    readnum = n; loadb = 1'b1;
    tick();
    loadb = 1'b0;
  endtask

  task automatic op(input logic [2:0] o, input logic as, input logic bs, input logic [1:0] sh,
                    input logic [15:0] imm5, input logic [15:0] ec, input logic [2:0] es);
    aluop = o; asel = as; bsel = bs; shift = sh; sximm5 = imm5;
    loadc = 1'b1; loads = 1'b1;
    exp_q.push_back({ec, es});
    tick();
    loadc = 1'b0; loads = 1'b0;
  endtask

  task automatic wait_idle();
    cyc = 0;
    while (mul_busy && cyc < 200) begin
      cyc++;
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; write = 1'b0; writenum = '0; readnum = '0; vsel = '0;
    mdata = '0; sximm8 = '0; sximm5 = '0; pc = '0; loada = 1'b0; loadb = 1'b0;
    asel = 1'b0; bsel = 1'b0; shift = SH_NONE; aluop = ALU_ADD;
    loadc = 1'b0; loads = 1'b0; mul_start = 1'b0;
    #2;
    chk("reset_c", c_out, 16'h0000);
    chk("reset_status", 16'(status_out), 16'h0000);
    chk("reset_busy", 16'(mul_busy), 16'h0000);
    chk("reset_done", 16'(mul_done), 16'h0000);
    @(posedge clk); #1;
    reset = 1'b0;
    tick();

    // ADD with signed overflow, SUB to zero, NOT B
    wr(3'd1, 16'h7FFF);
    wr(3'd2, 16'h0001);
    ld_a(3'd1);
    ld_b(3'd2);
    op(ALU_ADD, 1'b0, 1'b0, SH_NONE, 16'h0, 16'h8000, 3'b110);
    ld_a(3'd2);
    op(ALU_SUB, 1'b0, 1'b0, SH_NONE, 16'h0, 16'h0000, 3'b001);
    wr(3'd4, 16'h00F0);
    ld_b(3'd4);
    op(ALU_NOT, 1'b0, 1'b0, SH_NONE, 16'h0, 16'hFF0F, 3'b010);

    // Shifter on B=0x8001 via pass-Bin, then sximm5 override
    wr(3'd5, 16'h8001);
    ld_b(3'd5);
    op(3'b110, 1'b0, 1'b0, SH_ASR, 16'h0, 16'hC000, 3'b010);
    op(3'b111, 1'b0, 1'b0, SH_LSR, 16'h0, 16'h4000, 3'b000);
    op(3'b110, 1'b0, 1'b0, SH_LSL, 16'h0, 16'h0002, 3'b000);
    op(3'b110, 1'b0, 1'b1, SH_ASR, 16'hFFF0, 16'hFFF0, 3'b010);

    // Logic ops and overflow boundaries with A=0x7FFF, B=0x8001
    ld_a(3'd1);
    op(ALU_AND, 1'b0, 1'b0, SH_NONE, 16'h0, 16'h0001, 3'b000);
    op(ALU_OR,  1'b0, 1'b0, SH_NONE, 16'h0, 16'hFFFF, 3'b010);
    op(ALU_XOR, 1'b0, 1'b0, SH_NONE, 16'h0, 16'hFFFE, 3'b010);
    op(ALU_ADD, 1'b0, 1'b0, SH_NONE, 16'h0, 16'h0000, 3'b001);
    op(ALU_SUB, 1'b0, 1'b0, SH_NONE, 16'h0, 16'hFFFE, 3'b110);
    op(ALU_ADD, 1'b1, 1'b0, SH_NONE, 16'h0, 16'h8001, 3'b010);

    // Write->read bypass into A
    write = 1'b1; writenum = 3'd3; vsel = 4'b0100; sximm8 = 16'h1234;
    readnum = 3'd3; loada = 1'b1;
    tick();
    write = 1'b0; vsel = 4'b0000; loada = 1'b0;
    op(ALU_ADD, 1'b0, 1'b1, SH_NONE, 16'h0, 16'h1234, 3'b000);

    // Writeback sources: pc zero-extend, mdata, none, OR of two
    pc = 9'h1FF;
    wrv(3'd6, 4'b0010);
    ld_a(3'd6);
    op(ALU_ADD, 1'b0, 1'b1, SH_NONE, 16'h0, 16'h01FF, 3'b000);
    mdata = 16'hA5A5;
    wrv(3'd7, 4'b1000);
    ld_a(3'd7);
    op(ALU_ADD, 1'b0, 1'b1, SH_NONE, 16'h0, 16'hA5A5, 3'b010);
    wrv(3'd7, 4'b0000);
    ld_a(3'd7);
    op(ALU_ADD, 1'b0, 1'b1, SH_NONE, 16'h0, 16'h0000, 3'b001);
    mdata = 16'h0F00; sximm8 = 16'h00F0;
    wrv(3'd6, 4'b1100);
    ld_a(3'd6);
    op(ALU_ADD, 1'b0, 1'b1, SH_NONE, 16'h0, 16'h0FF0, 3'b000);

    // MUL 0x0100 * 0x0300: low half zero, high half nonzero
    wr(3'd1, 16'h0100);
    wr(3'd2, 16'h0300);
    ld_a(3'd1);
    ld_b(3'd2);
    asel = 1'b0; bsel = 1'b0; shift = SH_NONE;
    exp_q.push_back({16'h0000, 3'b101});
    mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    chk("mul1_busy_rise", 16'(mul_busy), 16'h0001);
    wait_idle();
    chk("mul1_busy_cycles", 16'(cyc), 16'd16);
    chk("mul1_done_pulse", 16'(mul_done), 16'h0001);
    tick();
    chk("mul1_done_clear", 16'(mul_done), 16'h0000);

    // MUL 7*6 with mul_start and loadc attempted while busy
    wr(3'd1, 16'h0007);
    wr(3'd2, 16'h0006);
    ld_a(3'd1);
    ld_b(3'd2);
    exp_q.push_back({16'h002A, 3'b000});
    mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    tick();
    tick();
    mul_start = 1'b1; aluop = 3'b110; bsel = 1'b1; sximm5 = 16'h5555;
    loadc = 1'b1; loads = 1'b1;
    tick();
    mul_start = 1'b0; loadc = 1'b0; loads = 1'b0; bsel = 1'b0;
    chk("busy_loadc_ignored", c_out, 16'h0000);
    chk("busy_loads_ignored", 16'(status_out), 16'h0005);
    wait_idle();
    chk("mul2_done_pulse", 16'(mul_done), 16'h0001);
    tick();
    chk("busy_start_ignored", 16'(mul_busy), 16'h0000);

    // loadc and mul_start in the same idle cycle
    aluop = ALU_ADD; asel = 1'b0; bsel = 1'b0; shift = SH_NONE;
    loadc = 1'b1; loads = 1'b1; mul_start = 1'b1;
    exp_q.push_back({16'h000D, 3'b000});
    exp_q.push_back({16'h002A, 3'b000});
    tick();
    loadc = 1'b0; loads = 1'b0; mul_start = 1'b0;
    chk("both_busy", 16'(mul_busy), 16'h0001);
    wait_idle();
    chk("both_done", 16'(mul_done), 16'h0001);
    tick();

    // Async reset between edges in the middle of a multiply
    mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    repeat (5) tick();
    chk("mid_busy", 16'(mul_busy), 16'h0001);
    #1 reset = 1'b1;
    #1;
    chk("rst_busy", 16'(mul_busy), 16'h0000);
    chk("rst_done", 16'(mul_done), 16'h0000);
    chk("rst_c", c_out, 16'h0000);
    chk("rst_status", 16'(status_out), 16'h0000);
    #1 reset = 1'b0;
    tick();
    ld_a(3'd1);
    op(ALU_ADD, 1'b0, 1'b1, SH_NONE, 16'h0, 16'h0000, 3'b001);
    ld_a(3'd3);
    op(ALU_ADD, 1'b0, 1'b1, SH_NONE, 16'h0, 16'h0000, 3'b001);
    repeat (20) tick();
    chk("post_rst_idle", 16'(mul_busy), 16'h0000);
    chk("queue_empty", 16'(exp_q.size()), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
